// File: rtl/mem_bus_arbiter_if.sv
// Two requesters plus the shared single-beat memory bus, as seen by the arbiter.
// slave: arbiter side; master: requesters and the memory behind the bus.
interface mem_bus_arbiter_if;
   logic        m0_req;
   logic [15:0] m0_addr;
   logic        m0_we;
   logic [7:0]  m0_wdata;
   logic        m0_ack;
   logic [7:0]  m0_rdata;

   logic        m1_req;
   logic [15:0] m1_addr;
   logic        m1_we;
   logic [7:0]  m1_wdata;
   logic        m1_ack;
   logic [7:0]  m1_rdata;

   logic        bus_sel;
   logic [15:0] bus_addr;
   logic        bus_we;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic [1:0]  grant;

   modport slave (
      input  m0_req, m0_addr, m0_we, m0_wdata,
      input  m1_req, m1_addr, m1_we, m1_wdata,
      input  bus_rdata,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output bus_sel, bus_addr, bus_we, bus_wdata, grant
   );

   modport master (
      output m0_req, m0_addr, m0_we, m0_wdata,
      output m1_req, m1_addr, m1_we, m1_wdata,
      output bus_rdata,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  bus_sel, bus_addr, bus_we, bus_wdata, grant
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter driving one registered single-beat memory transaction at a time.
// Latency: 2+wait cycles req-to-ack; non-owners are held off until the arbiter returns to IDLE.
module mem_bus_arbiter #(
   parameter int ROM_WAIT   = 1,
   parameter int RAM_WAIT   = 0,
   parameter int OTHER_WAIT = 0
) (
   input logic            clock,
   input logic            reset,
   mem_bus_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]  state;
   logic        last_owner;
   logic [3:0]  wait_cnt;
   logic        pick_any;
   logic        pick_m1;
   logic [15:0] win_addr;

   function automatic logic [3:0] region_wait(input logic [15:0] a);
      logic [3:0] w;
      if (a[15:10] == 6'd0)
         w = 4'(ROM_WAIT);
      else if (a[15:10] == 6'd1)
         w = 4'(RAM_WAIT);
      else
         w = 4'(OTHER_WAIT);
      return w;
   endfunction

   // On a tie the master that did not own the bus last wins.
   always_comb begin
      pick_any = bus.m0_req | bus.m1_req;
      pick_m1  = bus.m1_req & (~bus.m0_req | ~last_owner);
      win_addr = pick_m1 ? bus.m1_addr : bus.m0_addr;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         last_owner   <= 1'b1;
         wait_cnt     <= 4'd0;
         bus.bus_sel  <= 1'b0;
         bus.bus_we   <= 1'b0;
         bus.bus_addr <= 16'd0;
         bus.bus_wdata <= 8'd0;
         bus.grant    <= 2'b00;
         bus.m0_ack   <= 1'b0;
         bus.m1_ack   <= 1'b0;
         bus.m0_rdata <= 8'd0;
         bus.m1_rdata <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  bus.grant     <= pick_m1 ? 2'b10 : 2'b01;
                  bus.bus_addr  <= win_addr;
                  bus.bus_we    <= pick_m1 ? bus.m1_we : bus.m0_we;
                  bus.bus_wdata <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                  bus.bus_sel   <= 1'b1;
                  wait_cnt      <= region_wait(win_addr);
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  // grant still names the owner during the last ACCESS cycle
                  if (!bus.bus_we) begin
                     if (bus.grant[1])
                        bus.m1_rdata <= bus.bus_rdata;
                     else
                        bus.m0_rdata <= bus.bus_rdata;
                  end
                  bus.bus_sel <= 1'b0;
                  bus.bus_we  <= 1'b0;
                  bus.grant   <= 2'b00;
                  bus.m0_ack  <= bus.grant[0];
                  bus.m1_ack  <= bus.grant[1];
                  last_owner  <= bus.grant[1];
                  state       <= RESP;
               end
            end
            RESP: begin
               bus.m0_ack <= 1'b0;
               bus.m1_ack <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
